// File: rtl/top.sv
// Dual pseudo-random "spinner": two independent LFSR-driven channels that burst, slow and freeze.
// Define TOP_SLOWDOWN_EN for a growing update interval (2,4,...,16 cycles); otherwise every interval is 4 cycles.

module top_chan #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned N_UPDATES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic [3:0] o_value
);
    localparam int unsigned CNT_W = $clog2(2 * N_UPDATES + 1);
    localparam int unsigned K_W   = $clog2(N_UPDATES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_lfsr;
    logic               r_start_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [K_W-1:0]     r_k;
    logic [K_W-1:0]     w_k_nxt;
    logic [3:0]         r_out;
    logic [3:0]         w_out_nxt;
    logic               w_rise;
    logic               w_fb;
    logic [CNT_W-1:0]   w_limit;
    logic               w_hit;
    logic               w_final;

    assign w_rise = i_start & ~r_start_q;
    assign w_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Last count of the current interval: interval(k) - 1
`ifdef TOP_SLOWDOWN_EN
    assign w_limit = CNT_W'({r_k, 1'b1});
`else
    assign w_limit = CNT_W'(3);
`endif

    assign w_hit   = (r_cnt == w_limit);
    assign w_final = (r_k == K_W'(N_UPDATES - 1));

    // LFSR free-runs regardless of FSM state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr    <= SEED;
            r_start_q <= 1'b0;
        end else begin
            r_lfsr    <= {w_fb, r_lfsr[15:1]};
            r_start_q <= i_start;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_out   <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // A rise during RUN is deliberately ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_out_nxt   = r_out;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_rise) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (w_hit) begin
                    w_out_nxt = r_lfsr[3:0];
                    w_cnt_nxt = '0;
                    w_k_nxt   = r_k + K_W'(1);
                    if (w_final) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_value = r_out;
endmodule

module top #(
    parameter logic [15:0] SEED_1    = 16'hACE1,
    parameter logic [15:0] SEED_2    = 16'h1D2B,
    parameter int unsigned N_UPDATES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_start_2,
    output logic [3:0] o_random_out,
    output logic [3:0] o_random_out_2
);
    top_chan #(
        .SEED      (SEED_1),
        .N_UPDATES (N_UPDATES)
    ) u_ch1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .o_value (o_random_out)
    );

    top_chan #(
        .SEED      (SEED_2),
        .N_UPDATES (N_UPDATES)
    ) u_ch2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start_2),
        .o_value (o_random_out_2)
    );
endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the dual spinner; honours TOP_SLOWDOWN_EN like the design.

module tb_top;
    localparam logic [15:0] SEED_1 = 16'hACE1;
    localparam logic [15:0] SEED_2 = 16'h1D2B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s1;
    logic       s2;
    logic [3:0] o1;
    logic [3:0] o2;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] e1 = 4'h0;
    logic [3:0] e2 = 4'h0;
    bit aborted;

`ifdef TOP_SLOWDOWN_EN
    int upd_tbl [8] = '{2, 6, 12, 20, 30, 42, 56, 72};
`else
    int upd_tbl [8] = '{4, 8, 12, 16, 20, 24, 28, 32};
`endif

    always #5 clk = ~clk;

    top #(
        .SEED_1    (SEED_1),
        .SEED_2    (SEED_2),
        .N_UPDATES (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (s1),
        .i_start_2      (s2),
        .o_random_out   (o1),
        .o_random_out_2 (o2)
    );

    function automatic logic [15:0] nx(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reference LFSRs; m*_at holds the value present at the most recent edge
    logic [15:0] m1, m2, m1_at, m2_at;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= SEED_1; m2 <= SEED_2; m1_at <= SEED_1; m2_at <= SEED_2;
        end else begin
            m1_at <= m1; m2_at <= m2;
            m1 <= nx(m1); m2 <= nx(m2);
        end
    end

    function automatic bit is_upd(input int n);
        for (int k = 0; k < 8; k++) if (upd_tbl[k] == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has start(s) high so the next edge is E0
    task automatic run(input bit a, input bit b, input int pulse_at, input int rst_at, output bit ab);
        ab = 1'b0;
        for (int n = 0; n <= upd_tbl[7] + 8; n++) begin
            tick();
            if (a && is_upd(n)) e1 = m1_at[3:0];
            if (b && is_upd(n)) e2 = m2_at[3:0];
            chk("out1", {12'h0, o1}, {12'h0, e1});
            chk("out2", {12'h0, o2}, {12'h0, e2});
            if (n == pulse_at)     s1 = 1'b0;
            if (n == pulse_at + 1) s1 = 1'b1;
            if (n == rst_at) begin
                rst_n = 1'b0;
                e1 = 4'h0;
                e2 = 4'h0;
                #1;
                chk("rst_async_out1", {12'h0, o1}, 16'h0);
                chk("rst_async_out2", {12'h0, o2}, 16'h0);
                ab = 1'b1;
                return;
            end
        end
    endtask

    task automatic launch(input bit a, input bit b, input int pulse_at, input int rst_at, output bit ab);
        s1 = 1'b0;
        s2 = 1'b0;
        tick();
        if (a) s1 = 1'b1;
        if (b) s2 = 1'b1;
        run(a, b, pulse_at, rst_at, ab);
    endtask

    initial begin
        rst_n = 1'b0;
        s1 = 1'b0;
        s2 = 1'b0;
        repeat (2) tick();
        chk("reset_out1", {12'h0, o1}, 16'h0);
        chk("reset_out2", {12'h0, o2}, 16'h0);
        chk("reset_lfsr1", dut.u_ch1.r_lfsr, 16'hACE1);
        chk("reset_lfsr2", dut.u_ch2.r_lfsr, 16'h1D2B);
        rst_n = 1'b1;
        tick();
        chk("lfsr1_step1", dut.u_ch1.r_lfsr, 16'h5670);
        tick();
        chk("lfsr1_step2", dut.u_ch1.r_lfsr, 16'hAB38);
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("idle_out1", {12'h0, o1}, 16'h0);
            chk("idle_out2", {12'h0, o2}, 16'h0);
            chk("idle_lfsr1", dut.u_ch1.r_lfsr, m1);
            chk("idle_lfsr2", dut.u_ch2.r_lfsr, m2);
        end

        // Single launch, start held high throughout
        launch(1'b1, 1'b0, -1, -1, aborted);
        // Re-pulse while running: must not restart
        launch(1'b1, 1'b0, 20, -1, aborted);
        // Fresh launch after DONE
        launch(1'b1, 1'b0, -1, -1, aborted);
        // Both channels launched on the same edge
        launch(1'b1, 1'b1, -1, -1, aborted);

        // Reset mid-run, then release with both starts held high
        launch(1'b1, 1'b1, -1, 30, aborted);
        chk("rst_taken", {15'h0, aborted}, 16'h1);
        repeat (2) begin
            tick();
            chk("in_reset_out1", {12'h0, o1}, 16'h0);
            chk("in_reset_out2", {12'h0, o2}, 16'h0);
        end
        rst_n = 1'b1;
        run(1'b1, 1'b1, -1, -1, aborted);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
